banked_register_file: RTL and testbench

- Next-generation CPU register file with three additions:
  - BANKS register banks (shadow contexts for interrupt entry/exit).
  - RD_PORTS read ports with per-port byte/word read size.
  - Byte-lane writes with same-cycle write-to-read bypass.
- The PC lives inside the block at PC_ADDR. It is shared by all banks and has its own increment path.
- A context engine switches the active bank, optionally copying the active bank into the target bank first.

---
 rtl/banked_register_file_if.sv | 34 +++
 rtl/banked_register_file.sv | 105 ++++++++++
 tb/tb_banked_register_file.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/banked_register_file_if.sv
// banked_register_file_if: write, read, PC and context-engine signals of the banked register file
interface banked_register_file_if #(
    parameter int REG_WIDTH = 16,
    parameter int REG_COUNT = 8,
    parameter int RD_PORTS = 2,
    parameter int BANKS = 2
);
    localparam int LANES = REG_WIDTH / 8;
    localparam int AW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    logic [LANES-1:0] wr_en;
    logic [AW-1:0] wr_addr;
    logic [REG_WIDTH-1:0] wr_data;
    logic [RD_PORTS*AW-1:0] rd_addr;
    logic [RD_PORTS-1:0] rd_size;
    logic [RD_PORTS*REG_WIDTH-1:0] rd_data;
    logic pc_inc;
    logic [REG_WIDTH-1:0] pc_out;
    logic ctx_start;
    logic ctx_copy;
    logic [BW-1:0] ctx_target;
    logic ctx_busy;
    logic ctx_done;
    logic [BW-1:0] active_bank;
    logic wr_drop;
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_size, pc_inc, ctx_start, ctx_copy, ctx_target,
        input rd_data, pc_out, ctx_busy, ctx_done, active_bank, wr_drop
    );
    modport slave (
        input wr_en, wr_addr, wr_data, rd_addr, rd_size, pc_inc, ctx_start, ctx_copy, ctx_target,
        output rd_data, pc_out, ctx_busy, ctx_done, active_bank, wr_drop
    );
endinterface

// File: rtl/banked_register_file.sv
// banked_register_file: multi-bank register file with shared PC, byte-lane writes, bypassed reads and a bank copy/switch engine
module banked_register_file #(
    parameter int REG_WIDTH = 16,
    parameter int REG_COUNT = 8,
    parameter int RD_PORTS = 2,
    parameter int BANKS = 2,
    parameter int PC_ADDR = REG_COUNT - 1,
    parameter int PC_STEP = 2,
    parameter int PC_RESET = 0
) (
    input logic clk,
    input logic rst,
    banked_register_file_if.slave bus
);
    localparam int LANES = REG_WIDTH / 8;
    localparam int AW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    typedef enum logic [1:0] {IDLE, COPY, SWITCH} state_t;
    state_t state, state_nxt;
    logic [REG_WIDTH-1:0] regs [BANKS][REG_COUNT];
    logic [REG_WIDTH-1:0] pc;
    logic [BW-1:0] active, target, target_nxt, req_bank;
    logic [AW-1:0] idx, idx_nxt;
    logic busy, done, drop;
    logic wr_any, wr_in_range, wr_pc, wr_reg, wr_drop_now;
    function automatic logic [REG_WIDTH-1:0] merge(
        input logic [REG_WIDTH-1:0] old,
        input logic [REG_WIDTH-1:0] data,
        input logic [LANES-1:0] en
    );
        logic [REG_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = en[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
    assign busy = state != IDLE;
    assign wr_any = |bus.wr_en;
    assign wr_pc = wr_any && bus.wr_addr == AW'(PC_ADDR);
    assign wr_in_range = {1'b0, bus.wr_addr} < (AW+1)'(REG_COUNT);
    assign wr_reg = wr_any && wr_in_range && !wr_pc && !busy;
    assign wr_drop_now = wr_any && wr_in_range && !wr_pc && busy;
    // a nonexistent target bank degenerates to a request for the bank already active
    assign req_bank = {1'b0, bus.ctx_target} < (BW+1)'(BANKS) ? bus.ctx_target : active;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            target <= '0;
            idx <= '0;
        end else begin
            state <= state_nxt;
            target <= target_nxt;
            idx <= idx_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        target_nxt = target;
        idx_nxt = idx;
        if (state == IDLE && bus.ctx_start) begin
            target_nxt = req_bank;
            idx_nxt = '0;
            state_nxt = bus.ctx_copy && req_bank != active ? COPY : SWITCH;
        end else if (state == COPY) begin
            idx_nxt = idx + AW'(1);
            state_nxt = idx == AW'(REG_COUNT - 1) ? SWITCH : COPY;
        end else if (state == SWITCH) begin
            state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            done <= 1'b0;
            drop <= 1'b0;
            pc <= REG_WIDTH'(PC_RESET);
            for (int b = 0; b < BANKS; b++)
                for (int r = 0; r < REG_COUNT; r++) regs[b][r] <= '0;
        end else begin
            done <= state == SWITCH;
            drop <= wr_drop_now;
            if (state == SWITCH) active <= target;
            pc <= wr_pc ? merge(pc, bus.wr_data, bus.wr_en) : bus.pc_inc ? pc + REG_WIDTH'(PC_STEP) : pc;
            if (wr_reg) regs[active][bus.wr_addr] <= merge(regs[active][bus.wr_addr], bus.wr_data, bus.wr_en);
            // the PC slot is skipped but still costs its cycle, keeping copy latency fixed
            if (state == COPY && idx != AW'(PC_ADDR)) regs[target][idx] <= regs[active][idx];
        end
    end
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] a;
        logic [REG_WIDTH-1:0] word, hit;
        logic is_pc, in_range, bypass;
        assign a = bus.rd_addr[p*AW +: AW];
        assign is_pc = a == AW'(PC_ADDR);
        assign in_range = {1'b0, a} < (AW+1)'(REG_COUNT);
        assign word = is_pc ? pc : in_range ? regs[active][a] : '0;
        assign bypass = is_pc ? wr_pc : wr_reg && bus.wr_addr == a;
        assign hit = bypass ? merge(word, bus.wr_data, bus.wr_en) : word;
        assign bus.rd_data[p*REG_WIDTH +: REG_WIDTH] = bus.rd_size[p] ? hit : {{(REG_WIDTH-8){hit[7]}}, hit[7:0]};
    end
    assign bus.pc_out = pc;
    assign bus.ctx_busy = busy;
    assign bus.ctx_done = done;
    assign bus.active_bank = active;
    assign bus.wr_drop = drop;
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: directed vector table plus context-engine sequences for banked_register_file
module tb_banked_register_file;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    banked_register_file_if #(.REG_WIDTH(16), .REG_COUNT(8), .RD_PORTS(2), .BANKS(2)) bus ();
    banked_register_file #(.REG_WIDTH(16), .REG_COUNT(8), .RD_PORTS(2), .BANKS(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct packed {
        logic [1:0] en;
        logic [2:0] wa;
        logic [15:0] wd;
        logic pinc;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [1:0] sz;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] epc;
    } vec_t;
    vec_t vecs[16];
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.wr_en = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.pc_inc = 1'b0;
        bus.ctx_start = 1'b0;
        bus.ctx_copy = 1'b0;
        bus.ctx_target = '0;
    endtask
    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        bus.wr_en = 2'b11;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 2'b00;
    endtask
    task automatic switch_only(input logic t);
        bus.ctx_start = 1'b1;
        bus.ctx_copy = 1'b0;
        bus.ctx_target = t;
        tick();
        bus.ctx_start = 1'b0;
        tick();
        check("switch_done", {15'b0, bus.ctx_done}, 16'd1);
        check("switch_bank", {15'b0, bus.active_bank}, {15'b0, t});
    endtask
    initial begin
        int busy_n;
        int done_at;
        int done_seen;
        vecs[0]  = '{2'b11, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd0, 2'b11, 16'h1234, 16'h0000, 16'h0000};
        vecs[1]  = '{2'b01, 3'd3, 16'h00AB, 1'b0, 3'd3, 3'd3, 2'b11, 16'h12AB, 16'h12AB, 16'h0000};
        vecs[2]  = '{2'b00, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd3, 2'b01, 16'h12AB, 16'hFFAB, 16'h0000};
        vecs[3]  = '{2'b11, 3'd2, 16'h0080, 1'b0, 3'd2, 3'd2, 2'b10, 16'hFF80, 16'h0080, 16'h0000};
        vecs[4]  = '{2'b11, 3'd2, 16'h017F, 1'b0, 3'd2, 3'd2, 2'b10, 16'h007F, 16'h017F, 16'h0000};
        vecs[5]  = '{2'b10, 3'd2, 16'hAA00, 1'b0, 3'd2, 3'd2, 2'b01, 16'hAA7F, 16'h007F, 16'h0000};
        vecs[6]  = '{2'b11, 3'd7, 16'hFFFE, 1'b0, 3'd7, 3'd7, 2'b01, 16'hFFFE, 16'hFFFE, 16'h0000};
        vecs[7]  = '{2'b00, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd3, 2'b11, 16'hFFFE, 16'h12AB, 16'hFFFE};
        vecs[8]  = '{2'b00, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd2, 2'b11, 16'h0000, 16'hAA7F, 16'h0000};
        vecs[9]  = '{2'b11, 3'd7, 16'h0100, 1'b1, 3'd7, 3'd7, 2'b11, 16'h0100, 16'h0100, 16'h0002};
        vecs[10] = '{2'b00, 3'd0, 16'h0000, 1'b0, 3'd7, 3'd5, 2'b11, 16'h0100, 16'h0000, 16'h0100};
        vecs[11] = '{2'b01, 3'd7, 16'h0034, 1'b1, 3'd7, 3'd7, 2'b01, 16'h0134, 16'h0034, 16'h0100};
        vecs[12] = '{2'b00, 3'd0, 16'h0000, 1'b0, 3'd7, 3'd4, 2'b11, 16'h0134, 16'h0000, 16'h0134};
        vecs[13] = '{2'b00, 3'd3, 16'hFFFF, 1'b0, 3'd3, 3'd3, 2'b11, 16'h12AB, 16'h12AB, 16'h0134};
        vecs[14] = '{2'b00, 3'd7, 16'h5555, 1'b1, 3'd7, 3'd6, 2'b11, 16'h0134, 16'h0000, 16'h0134};
        vecs[15] = '{2'b00, 3'd0, 16'h0000, 1'b0, 3'd7, 3'd7, 2'b01, 16'h0136, 16'h0036, 16'h0136};
        idle();
        bus.rd_addr = '0;
        bus.rd_size = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus.rd_addr = {3'(7 - r), 3'(r)};
            #1;
            check("reset_rd0", bus.rd_data[15:0], 16'h0000);
            check("reset_rd1", bus.rd_data[31:16], 16'h0000);
        end
        check("reset_pc", bus.pc_out, 16'h0000);
        check("reset_bank", {15'b0, bus.active_bank}, 16'd0);
        check("reset_busy", {15'b0, bus.ctx_busy}, 16'd0);
        check("reset_done", {15'b0, bus.ctx_done}, 16'd0);
        check("reset_drop", {15'b0, bus.wr_drop}, 16'd0);
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = vecs[i].en;
            bus.wr_addr = vecs[i].wa;
            bus.wr_data = vecs[i].wd;
            bus.pc_inc = vecs[i].pinc;
            bus.rd_addr = {vecs[i].ra1, vecs[i].ra0};
            bus.rd_size = vecs[i].sz;
            #1;
            check($sformatf("vec%0d_rd0", i), bus.rd_data[15:0], vecs[i].e0);
            check($sformatf("vec%0d_rd1", i), bus.rd_data[31:16], vecs[i].e1);
            check($sformatf("vec%0d_pc", i), bus.pc_out, vecs[i].epc);
            tick();
        end
        idle();
        bus.rd_size = 2'b11;
        bus.rd_addr = {3'd1, 3'd1};
        write_reg(3'd1, 16'hBEEF);
        bus.ctx_start = 1'b1;
        bus.ctx_copy = 1'b0;
        bus.ctx_target = 1'b1;
        tick();
        bus.ctx_start = 1'b0;
        #1;
        check("sw_busy", {15'b0, bus.ctx_busy}, 16'd1);
        check("sw_old_bank_read", bus.rd_data[15:0], 16'hBEEF);
        tick();
        check("sw_done", {15'b0, bus.ctx_done}, 16'd1);
        check("sw_bank1", {15'b0, bus.active_bank}, 16'd1);
        check("sw_new_bank_read", bus.rd_data[15:0], 16'h0000);
        tick();
        check("sw_done_pulse", {15'b0, bus.ctx_done}, 16'd0);
        write_reg(3'd1, 16'h1111);
        switch_only(1'b0);
        check("sw_back_read", bus.rd_data[15:0], 16'hBEEF);
        bus.ctx_start = 1'b1;
        bus.ctx_copy = 1'b1;
        bus.ctx_target = 1'b0;
        tick();
        bus.ctx_start = 1'b0;
        tick();
        check("self_copy_done", {15'b0, bus.ctx_done}, 16'd1);
        check("self_copy_bank", {15'b0, bus.active_bank}, 16'd0);
        for (int r = 0; r < 7; r++) write_reg(3'(r), 16'(r + 1));
        bus.ctx_start = 1'b1;
        bus.ctx_copy = 1'b1;
        bus.ctx_target = 1'b1;
        bus.rd_addr = '0;
        busy_n = 0;
        done_at = 0;
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            tick();
            bus.ctx_start = c == 2;
            bus.ctx_copy = 1'b0;
            bus.ctx_target = 1'b0;
            bus.wr_en = c == 3 ? 2'b11 : 2'b00;
            bus.wr_addr = 3'd0;
            bus.wr_data = 16'hDEAD;
            bus.pc_inc = c == 5;
            if (bus.ctx_busy) busy_n++;
            if (bus.ctx_done) done_at = c;
            if (c == 3) begin
                #1;
                check("drop_no_bypass", bus.rd_data[15:0], 16'h0001);
            end
            if (c == 4) check("wr_drop_pulse", {15'b0, bus.wr_drop}, 16'd1);
            if (c == 5) check("wr_drop_clear", {15'b0, bus.wr_drop}, 16'd0);
            if (c == 6) check("pc_inc_busy", bus.pc_out, 16'h0138);
        end
        idle();
        check("copy_busy_cycles", 16'(busy_n), 16'd9);
        check("copy_done_cycle", 16'(done_at), 16'd10);
        check("copy_bank", {15'b0, bus.active_bank}, 16'd1);
        for (int r = 0; r < 7; r++) begin
            bus.rd_addr = {3'd7, 3'(r)};
            #1;
            check($sformatf("copy_r%0d", r), bus.rd_data[15:0], 16'(r + 1));
        end
        check("copy_pc_shared", bus.rd_data[31:16], 16'h0138);
        tick();
        check("copy_done_pulse", {15'b0, bus.ctx_done}, 16'd0);
        switch_only(1'b0);
        bus.ctx_start = 1'b1;
        bus.ctx_copy = 1'b1;
        bus.ctx_target = 1'b1;
        tick();
        bus.ctx_start = 1'b0;
        tick();
        tick();
        check("abort_in_copy", {15'b0, bus.ctx_busy}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_bank", {15'b0, bus.active_bank}, 16'd0);
        check("abort_busy", {15'b0, bus.ctx_busy}, 16'd0);
        check("abort_pc", bus.pc_out, 16'h0000);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.ctx_done || bus.active_bank != 1'b0) done_seen++;
            tick();
        end
        check("abort_no_done", 16'(done_seen), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
